// File: rtl/dm_arbiter.sv
// Round-robin arbiter for the single-port data memory: CPU vs external port, with ext burst lock.
// Optional statistics counters are enabled with `define DM_ARB_STATS_EN.
module dm_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BITS  = 10,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    input  logic              ext_lock,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q
`ifdef DM_ARB_STATS_EN
    ,
    output logic [31:0]       cpu_grant_cnt,
    output logic [31:0]       ext_grant_cnt,
    output logic [31:0]       conflict_cnt
`endif
);

    localparam int unsigned BW = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              ext_gnt_q, ext_gnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              ext_rvalid_q, ext_rvalid_d;
    logic              mem_rden_q, mem_rden_d;
    logic              mem_wren_q, mem_wren_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              sel_ext_q, sel_ext_d;
    logic              last_ext_q, last_ext_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
    logic [DATA_W-1:0] ext_hold_q, ext_hold_d;
    logic              burst_open;
    logic              pick_ext;

    // Only the low MEM_BITS of each address reach the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[ADDR_W-1:MEM_BITS], ext_addr[ADDR_W-1:MEM_BITS]};

    always_comb begin
        state_d      = state_q;
        cpu_gnt_d    = 1'b0;
        ext_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        ext_rvalid_d = 1'b0;
        mem_rden_d   = 1'b0;
        mem_wren_d   = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        sel_ext_d    = sel_ext_q;
        last_ext_d   = last_ext_q;
        burst_d      = ext_lock ? burst_q : '0;
        cpu_hold_d   = cpu_hold_q;
        ext_hold_d   = ext_hold_q;

        burst_open = ext_lock && (burst_q < BURST_LIM);
        if (cpu_req && ext_req) pick_ext = burst_open || !last_ext_q;
        else                    pick_ext = ext_req;

        unique case (state_q)
            IDLE: begin
                if (cpu_req || ext_req) begin
                    state_d    = ISSUE;
                    sel_ext_d  = pick_ext;
                    last_ext_d = pick_ext;
                    cpu_gnt_d  = !pick_ext;
                    ext_gnt_d  = pick_ext;
                    if (pick_ext) begin
                        mem_rden_d                 = !ext_we;
                        mem_wren_d                 = ext_we;
                        mem_addr_d[MEM_BITS-1:0]   = ext_addr[MEM_BITS-1:0];
                        mem_wdata_d                = ext_wdata;
                        if (burst_open) burst_d    = burst_q + 1'b1;
                    end else begin
                        mem_rden_d                 = !cpu_we;
                        mem_wren_d                 = cpu_we;
                        mem_addr_d[MEM_BITS-1:0]   = cpu_addr[MEM_BITS-1:0];
                        mem_wdata_d                = cpu_wdata;
                        burst_d                    = '0;
                    end
                end
            end
            ISSUE: begin
                state_d      = mem_rden_q ? RESP : IDLE;
                cpu_rvalid_d = mem_rden_q && !sel_ext_q;
                ext_rvalid_d = mem_rden_q && sel_ext_q;
            end
            RESP: begin
                state_d = IDLE;
                if (cpu_rvalid_q) cpu_hold_d = mem_q;
                if (ext_rvalid_q) ext_hold_d = mem_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cpu_gnt_q    <= 1'b0;
            ext_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            ext_rvalid_q <= 1'b0;
            mem_rden_q   <= 1'b0;
            mem_wren_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            sel_ext_q    <= 1'b0;
            last_ext_q   <= 1'b1;
            burst_q      <= '0;
            cpu_hold_q   <= '0;
            ext_hold_q   <= '0;
        end else begin
            state_q      <= state_d;
            cpu_gnt_q    <= cpu_gnt_d;
            ext_gnt_q    <= ext_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            ext_rvalid_q <= ext_rvalid_d;
            mem_rden_q   <= mem_rden_d;
            mem_wren_q   <= mem_wren_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            sel_ext_q    <= sel_ext_d;
            last_ext_q   <= last_ext_d;
            burst_q      <= burst_d;
            cpu_hold_q   <= cpu_hold_d;
            ext_hold_q   <= ext_hold_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign ext_gnt    = ext_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign ext_rvalid = ext_rvalid_q;
    assign mem_rden   = mem_rden_q;
    assign mem_wren   = mem_wren_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    // Memory data is only valid in the RESP cycle; the hold registers cover the gaps.
    assign cpu_rdata  = cpu_rvalid_q ? mem_q : cpu_hold_q;
    assign ext_rdata  = ext_rvalid_q ? mem_q : ext_hold_q;

`ifdef DM_ARB_STATS_EN
    logic [31:0] cpu_cnt_q, cpu_cnt_d;
    logic [31:0] ext_cnt_q, ext_cnt_d;
    logic [31:0] conf_cnt_q, conf_cnt_d;

    always_comb begin
        cpu_cnt_d  = cpu_cnt_q;
        ext_cnt_d  = ext_cnt_q;
        conf_cnt_d = conf_cnt_q;
        if (cpu_gnt_q && cpu_cnt_q != '1) cpu_cnt_d = cpu_cnt_q + 32'd1;
        if (ext_gnt_q && ext_cnt_q != '1) ext_cnt_d = ext_cnt_q + 32'd1;
        if (state_q == IDLE && cpu_req && ext_req && conf_cnt_q != '1)
            conf_cnt_d = conf_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_cnt_q  <= '0;
            ext_cnt_q  <= '0;
            conf_cnt_q <= '0;
        end else begin
            cpu_cnt_q  <= cpu_cnt_d;
            ext_cnt_q  <= ext_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign cpu_grant_cnt = cpu_cnt_q;
    assign ext_grant_cnt = ext_cnt_q;
    assign conflict_cnt  = conf_cnt_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: transaction-scheduling reference model checked every cycle plus directed literal checks.
module tb_dm_arbiter;

    localparam int ADDR_W = 32, DATA_W = 32, MEM_BITS = 10, BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, ext_req = 1'b0, ext_we = 1'b0, ext_lock = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, ext_addr = '0, ext_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid, mem_rden, mem_wren;
    logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_q = '0;
`ifdef DM_ARB_STATS_EN
    logic [31:0] cpu_grant_cnt, ext_grant_cnt, conflict_cnt;
`endif

    dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BITS(MEM_BITS), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .ext_lock(ext_lock),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_q(mem_q)
`ifdef DM_ARB_STATS_EN
        , .cpu_grant_cnt(cpu_grant_cnt), .ext_grant_cnt(ext_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [9:0] a);
        return 32'hA500_0000 | ({22'b0, a} * 32'h101);
    endfunction

    // Data memory emulation: registered read, one cycle after rden.
    logic [31:0]   dm [1024];
    logic [1023:0] dm_wr = '0;
    always @(posedge clk) begin
        if (mem_wren) begin
            dm[mem_addr[9:0]]    <= mem_wdata;
            dm_wr[mem_addr[9:0]] <= 1'b1;
        end
        if (mem_rden) mem_q <= dm_wr[mem_addr[9:0]] ? dm[mem_addr[9:0]] : init_val(mem_addr[9:0]);
    end

    // Reference model: on each IDLE edge pick a winner and schedule its grant/response cycles.
    typedef struct packed {
        logic        cpu_gnt, ext_gnt, rden, wren;
        logic [31:0] addr, wdata;
        logic        cpu_rv, ext_rv;
        logic [31:0] rdata;
    } exp_t;

    exp_t          cur = '0, nxt = '0;
    int            busy = 0, run = 0;
    logic          last_ext = 1'b1;
    logic [31:0]   hold_c = '0, hold_e = '0;
    logic [31:0]   sh [1024];
    logic [1023:0] sh_wr = '0;
    int            m_cgc = 0, m_egc = 0, m_conf = 0;

    always @(posedge clk or posedge rst) begin : model
        exp_t        c, n;
        int          b, r;
        logic        le, pe, we_x;
        logic [31:0] ad, wd;
        logic [9:0]  a;
        if (rst) begin
            cur <= '0; nxt <= '0; busy <= 0; run <= 0; last_ext <= 1'b1;
            hold_c <= '0; hold_e <= '0; m_cgc <= 0; m_egc <= 0; m_conf <= 0;
        end else begin
            if (cur.cpu_rv) hold_c <= cur.rdata;
            if (cur.ext_rv) hold_e <= cur.rdata;
            if (cur.cpu_gnt) m_cgc <= m_cgc + 1;
            if (cur.ext_gnt) m_egc <= m_egc + 1;
            c = nxt; n = '0; b = busy; r = run; le = last_ext;
            if (b > 0) b = b - 1;
            else if (cpu_req || ext_req) begin
                if (cpu_req && ext_req) begin
                    pe = (ext_lock && r < BURST_MAX) || !le;
                    m_conf <= m_conf + 1;
                end else pe = ext_req;
                we_x = pe ? ext_we : cpu_we;
                ad   = pe ? ext_addr : cpu_addr;
                wd   = pe ? ext_wdata : cpu_wdata;
                a    = ad[9:0];
                c.cpu_gnt = !pe; c.ext_gnt = pe; c.rden = !we_x; c.wren = we_x;
                c.addr = {22'b0, a}; c.wdata = wd;
                if (we_x) begin
                    sh[a] <= wd; sh_wr[a] <= 1'b1; b = 1;
                end else begin
                    n.cpu_rv = !pe; n.ext_rv = pe;
                    n.rdata = sh_wr[a] ? sh[a] : init_val(a);
                    b = 2;
                end
                le = pe;
                if (pe && ext_lock) r = (r < BURST_MAX) ? r + 1 : r;
                else r = 0;
            end
            if (!ext_lock) r = 0;
            cur <= c; nxt <= n; busy <= b; run <= r; last_ext <= le;
        end
    end

    // Observed grant / response logs for the directed literal checks.
    int          gport[$], gcyc[$], rvport[$], rvcyc[$];
    logic [31:0] gaddr[$], gwren[$], rvdata[$];
    int          cstart[$], estart[$];

    always @(negedge clk) begin
        chk("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, cur.cpu_gnt});
        chk("ext_gnt", {31'b0, ext_gnt}, {31'b0, cur.ext_gnt});
        chk("mem_rden", {31'b0, mem_rden}, {31'b0, cur.rden});
        chk("mem_wren", {31'b0, mem_wren}, {31'b0, cur.wren});
        if (cur.rden || cur.wren) chk("mem_addr", mem_addr, cur.addr);
        if (cur.wren) chk("mem_wdata", mem_wdata, cur.wdata);
        chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, cur.cpu_rv});
        chk("ext_rvalid", {31'b0, ext_rvalid}, {31'b0, cur.ext_rv});
        chk("cpu_rdata", cpu_rdata, cur.cpu_rv ? cur.rdata : hold_c);
        chk("ext_rdata", ext_rdata, cur.ext_rv ? cur.rdata : hold_e);
`ifdef DM_ARB_STATS_EN
        chk("cpu_grant_cnt", cpu_grant_cnt, m_cgc);
        chk("ext_grant_cnt", ext_grant_cnt, m_egc);
        chk("conflict_cnt", conflict_cnt, m_conf);
`endif
        if (cpu_gnt) begin gport.push_back(0); gcyc.push_back(cyc); gaddr.push_back(mem_addr); gwren.push_back({31'b0, mem_wren}); end
        if (ext_gnt) begin gport.push_back(1); gcyc.push_back(cyc); gaddr.push_back(mem_addr); gwren.push_back({31'b0, mem_wren}); end
        if (cpu_rvalid) begin rvport.push_back(0); rvcyc.push_back(cyc); rvdata.push_back(cpu_rdata); end
        if (ext_rvalid) begin rvport.push_back(1); rvcyc.push_back(cyc); rvdata.push_back(ext_rdata); end
    end

    // Requester agents: present queue head, hold until gnt, advance the cycle after gnt.
    typedef struct packed { logic we; logic [31:0] addr, wdata; } cmd_t;
    cmd_t cq[$], eq[$];
    logic c_seen = 1'b0, e_seen = 1'b0;

    initial begin : cpu_agent
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                cq.delete(); c_seen = 1'b0; cpu_req = 1'b0;
            end else begin
                if (c_seen) void'(cq.pop_front());
                if (cq.size() > 0) begin
                    if (!cpu_req || c_seen) cstart.push_back(cyc);
                    cpu_req = 1'b1; cpu_we = cq[0].we; cpu_addr = cq[0].addr; cpu_wdata = cq[0].wdata;
                end else cpu_req = 1'b0;
                c_seen = cpu_gnt;
            end
        end
    end

    initial begin : ext_agent
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                eq.delete(); e_seen = 1'b0; ext_req = 1'b0;
            end else begin
                if (e_seen) void'(eq.pop_front());
                if (eq.size() > 0) begin
                    if (!ext_req || e_seen) estart.push_back(cyc);
                    ext_req = 1'b1; ext_we = eq[0].we; ext_addr = eq[0].addr; ext_wdata = eq[0].wdata;
                end else ext_req = 1'b0;
                e_seen = ext_gnt;
            end
        end
    end

    task automatic step();
        @(posedge clk); #3;
    endtask

    task automatic clr_logs();
        gport.delete(); gcyc.delete(); gaddr.delete(); gwren.delete();
        rvport.delete(); rvcyc.delete(); rvdata.delete(); cstart.delete(); estart.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((cq.size() != 0 || eq.size() != 0) && n < 300) begin step(); n++; end
        if (n >= 300) begin
            vectors++; miscompares++;
            $display("FAIL wait_idle: requests still pending after %0d cycles", n);
        end
        repeat (4) step();
    endtask

    function automatic logic [7:0] order8();
        logic [7:0] v = '0;
        for (int i = 0; i < 8 && i < gport.size(); i++) v[i] = gport[i][0];
        return v;
    endfunction

    initial begin : main
        int n;
        step(); step(); step();
        rst = 1'b0;
        #1;
        chk("reset_pulses", {26'b0, cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, mem_rden, mem_wren}, 32'd0);
        chk("reset_rdata", cpu_rdata | ext_rdata, 32'd0);
        step();

        // CPU write then read-back
        clr_logs();
        cq.push_back('{1'b1, 32'd5, 32'h1234});
        wait_idle();
        cq.push_back('{1'b0, 32'd5, 32'd0});
        wait_idle();
        chk("wr_rd_grants", gcyc.size(), 2);
        chk("wr_rd_rvalids", rvcyc.size(), 1);
        if (gcyc.size() == 2 && rvcyc.size() == 1 && cstart.size() == 2) begin
            chk("wr_gnt_latency", gcyc[0] - cstart[0], 1);
            chk("wr_mem_wren", gwren[0], 1);
            chk("wr_mem_addr", gaddr[0], 5);
            chk("rd_gnt_latency", gcyc[1] - cstart[1], 1);
            chk("rd_rvalid_latency", rvcyc[0] - cstart[1], 2);
            chk("rd_rdata", rvdata[0], 32'h1234);
        end

        // Tie after reset: CPU first, ext 3 cycles later
        do_reset();
        clr_logs();
        cq.push_back('{1'b0, 32'd7, 32'd0});
        eq.push_back('{1'b0, 32'd9, 32'd0});
        wait_idle();
        chk("tie_grants", gcyc.size(), 2);
        if (gcyc.size() == 2 && rvcyc.size() == 2 && cstart.size() == 1) begin
            chk("tie_first_port", gport[0], 0);
            chk("tie_second_port", gport[1], 1);
            chk("tie_cpu_gnt_at", gcyc[0] - cstart[0], 1);
            chk("tie_ext_gnt_at", gcyc[1] - cstart[0], 4);
            chk("tie_cpu_rdata", rvdata[0], 32'hA500_0707);
            chk("tie_ext_rdata", rvdata[1], 32'hA500_0909);
        end

        // Round-robin with continuous writes
        clr_logs();
        for (int i = 0; i < 4; i++) begin
            cq.push_back('{1'b1, 32'd16 + i, 32'hC000 + i});
            eq.push_back('{1'b1, 32'd32 + i, 32'hE000 + i});
        end
        wait_idle();
        chk("rr_grants", gcyc.size(), 8);
        chk("rr_order", {24'b0, order8()}, 32'h0000_00AA);
        if (gcyc.size() == 8) chk("rr_spacing", gcyc[1] - gcyc[0], 2);

        // Ext lock burst: 4 ext, 1 cpu, ext resumes
        clr_logs();
        ext_lock = 1'b1;
        for (int i = 0; i < 2; i++) cq.push_back('{1'b1, 32'd48 + i, 32'hCC00 + i});
        for (int i = 0; i < 6; i++) eq.push_back('{1'b1, 32'd64 + i, 32'hEE00 + i});
        wait_idle();
        ext_lock = 1'b0;
        chk("burst_grants", gcyc.size(), 8);
        chk("burst_order", {24'b0, order8()}, 32'h0000_006F);

        // Reset while a read is pending
        clr_logs();
        cq.push_back('{1'b0, 32'd3, 32'd0});
        n = 0;
        while (!cpu_gnt && n < 20) begin step(); n++; end
        chk("pending_read_granted", {31'b0, cpu_gnt}, 1);
        clr_logs();
        rst = 1'b1;
        #1;
        chk("async_rst_gnt", {31'b0, cpu_gnt}, 0);
        chk("async_rst_rden", {31'b0, mem_rden}, 0);
        step(); step();
        rst = 1'b0;
        repeat (4) step();
        chk("no_rvalid_after_rst", rvcyc.size(), 0);
        chk("no_gnt_after_rst", gcyc.size(), 0);
        cq.push_back('{1'b0, 32'd3, 32'd0});
        wait_idle();
        if (gcyc.size() == 1 && cstart.size() == 1) chk("post_rst_gnt_at", gcyc[0] - cstart[0], 1);
        else chk("post_rst_grants", gcyc.size(), 1);

        // Address wrap
        do_reset();
        clr_logs();
        cq.push_back('{1'b1, 32'h0000_0400, 32'hBEEF});
        wait_idle();
`ifdef DM_ARB_STATS_EN
        chk("stats_cpu_cnt", cpu_grant_cnt, 1);
        chk("stats_ext_cnt", ext_grant_cnt, 0);
`endif
        cq.push_back('{1'b0, 32'd0, 32'd0});
        wait_idle();
        chk("wrap_grants", gcyc.size(), 2);
        if (gcyc.size() == 2) chk("wrap_mem_addr", gaddr[0], 0);
        if (rvdata.size() == 1) chk("wrap_readback", rvdata[0], 32'hBEEF);
        else chk("wrap_rvalids", rvdata.size(), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
